// File: rtl/yuv_rgb.sv
// rtl/yuv_rgb.sv - four-stage YUV to RGB colour converter with saturation
module yuv_rgb #(
    parameter int ROUND = 1
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        in_valid,
    input  logic [15:0] ydata,
    input  logic [15:0] udata,
    input  logic [15:0] vdata,
    output logic        out_valid,
    output logic [15:0] rdata,
    output logic [15:0] gdata,
    output logic [15:0] bdata
);

    // Q2.13 coefficients, split into a high and a low group of set bits so
    // that each product is built from two partial shift-add sums in S2.
    localparam logic [15:0] KRV     = 16'd9339;
    localparam logic [15:0] KGU     = 16'd3236;
    localparam logic [15:0] KGV     = 16'd4760;
    localparam logic [15:0] KBU     = 16'd16646;
    localparam logic [15:0] LO_MASK = 16'h00FF;
    localparam logic [15:0] HI_MASK = 16'hFF00;

    localparam logic signed [33:0] RND = (ROUND != 0) ? 34'sd4096 : 34'sd0;

    // Sum of x shifted by every set bit of k: a constant multiply without a multiplier.
    function automatic logic signed [31:0] shift_add(input logic signed [16:0] x,
                                                     input logic [15:0] k);
        logic signed [31:0] acc;
        logic signed [31:0] xe;
        acc = '0;
        xe  = {{15{x[16]}}, x};
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                acc = acc + (xe <<< i);
            end
        end
        return acc;
    endfunction

    function automatic logic signed [33:0] sext34(input logic signed [31:0] x);
        return {{2{x[31]}}, x};
    endfunction

    function automatic logic [15:0] sat16(input logic signed [33:0] x);
        if (x < 34'sd0) begin
            return 16'h0000;
        end else if (x > 34'sd65535) begin
            return 16'hFFFF;
        end else begin
            return x[15:0];
        end
    endfunction

    logic signed [16:0] s1_y, s1_u, s1_v;
    logic               s1_vld;

    logic signed [16:0] s2_y;
    logic signed [31:0] s2_rv_hi, s2_rv_lo, s2_gu_hi, s2_gu_lo;
    logic signed [31:0] s2_gv_hi, s2_gv_lo, s2_bu_hi, s2_bu_lo;
    logic               s2_vld;

    logic signed [33:0] s3_r, s3_g, s3_b;
    logic               s3_vld;

    logic signed [33:0] r_sh, g_sh, b_sh;
    logic signed [33:0] s3_y_dummy;

    // S1: capture the sample, Y zero-extended and U/V sign-extended.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_y   <= '0;
            s1_u   <= '0;
            s1_v   <= '0;
            s1_vld <= 1'b0;
        end else if (clk_en) begin
            s1_y   <= {1'b0, ydata};
            s1_u   <= {udata[15], udata};
            s1_v   <= {vdata[15], vdata};
            s1_vld <= in_valid;
        end
    end

    // S2: partial products from the high and low coefficient bit groups.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s2_y     <= '0;
            s2_rv_hi <= '0;
            s2_rv_lo <= '0;
            s2_gu_hi <= '0;
            s2_gu_lo <= '0;
            s2_gv_hi <= '0;
            s2_gv_lo <= '0;
            s2_bu_hi <= '0;
            s2_bu_lo <= '0;
            s2_vld   <= 1'b0;
        end else if (clk_en) begin
            s2_y     <= s1_y;
            s2_rv_hi <= shift_add(s1_v, KRV & HI_MASK);
            s2_rv_lo <= shift_add(s1_v, KRV & LO_MASK);
            s2_gu_hi <= shift_add(s1_u, KGU & HI_MASK);
            s2_gu_lo <= shift_add(s1_u, KGU & LO_MASK);
            s2_gv_hi <= shift_add(s1_v, KGV & HI_MASK);
            s2_gv_lo <= shift_add(s1_v, KGV & LO_MASK);
            s2_bu_hi <= shift_add(s1_u, KBU & HI_MASK);
            s2_bu_lo <= shift_add(s1_u, KBU & LO_MASK);
            s2_vld   <= s1_vld;
        end
    end

    // Y is an integer, so adding it pre-scaled by 2^13 before the floor
    // shift gives exactly the same result as adding it afterwards.
    assign s3_y_dummy = {4'b0000, s2_y, 13'b0};

    // S3: finish the products and fold in Y.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s3_r   <= '0;
            s3_g   <= '0;
            s3_b   <= '0;
            s3_vld <= 1'b0;
        end else if (clk_en) begin
            s3_r   <= s3_y_dummy + sext34(s2_rv_hi) + sext34(s2_rv_lo);
            s3_g   <= s3_y_dummy - sext34(s2_gu_hi) - sext34(s2_gu_lo)
                                 - sext34(s2_gv_hi) - sext34(s2_gv_lo);
            s3_b   <= s3_y_dummy + sext34(s2_bu_hi) + sext34(s2_bu_lo);
            s3_vld <= s2_vld;
        end
    end

    // Rounding constant plus arithmetic (floor) shift back to integer scale.
    always_comb begin
        r_sh = (s3_r + RND) >>> 13;
        g_sh = (s3_g + RND) >>> 13;
        b_sh = (s3_b + RND) >>> 13;
    end

    // S4: saturate and register the outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rdata     <= '0;
            gdata     <= '0;
            bdata     <= '0;
            out_valid <= 1'b0;
        end else if (clk_en) begin
            rdata     <= sat16(r_sh);
            gdata     <= sat16(g_sh);
            bdata     <= sat16(b_sh);
            out_valid <= s3_vld;
        end
    end

endmodule

// File: tb/tb_yuv_rgb.sv
// tb/tb_yuv_rgb.sv - self-checking bench for yuv_rgb
module tb_yuv_rgb;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        in_valid;
    logic [15:0] ydata, udata, vdata;
    logic        out_valid;
    logic [15:0] rdata, gdata, bdata;

    int n_vec = 0;
    int n_bad = 0;
    int seen_valid = 0;

    always #5 clock = ~clock;

    yuv_rgb #(.ROUND(1)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .in_valid (in_valid),
        .ydata    (ydata),
        .udata    (udata),
        .vdata    (vdata),
        .out_valid(out_valid),
        .rdata    (rdata),
        .gdata    (gdata),
        .bdata    (bdata)
    );

    typedef struct {
        logic        vld;
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
    } exp_t;

    typedef struct {
        logic [15:0] y;
        logic [15:0] u;
        logic [15:0] v;
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
    } vec_t;

    exp_t pipe_q[$];

    function automatic logic [15:0] clamp(input longint x);
        if (x < 0) return 16'd0;
        if (x > 65535) return 16'hFFFF;
        return x[15:0];
    endfunction

    // Reference: the conversion equations evaluated in 64-bit integers.
    function automatic exp_t model(input logic [15:0] y, input logic [15:0] u,
                                   input logic [15:0] v);
        exp_t   e;
        longint yy, uu, vv, rnd;
        yy  = longint'({48'd0, y});
        uu  = longint'($signed(u));
        vv  = longint'($signed(v));
        rnd = 4096;
        e.vld = 1'b1;
        e.r = clamp(yy + ((9339 * vv + rnd) >>> 13));
        e.g = clamp(yy + ((-3236 * uu - 4760 * vv + rnd) >>> 13));
        e.b = clamp(yy + ((16646 * uu + rnd) >>> 13));
        return e;
    endfunction

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with the given controls; checks against the reference queue.
    task automatic step(input logic en, input logic vld, input logic [15:0] y,
                        input logic [15:0] u, input logic [15:0] v);
        logic        pv;
        logic [15:0] pr, pg, pb;
        exp_t        e;
        exp_t        o;
        pv = out_valid; pr = rdata; pg = gdata; pb = bdata;
        clk_en = en; in_valid = vld; ydata = y; udata = u; vdata = v;
        @(posedge clock);
        #1;
        if (!en) begin
            chk1("stall_valid", out_valid, pv);
            chk16("stall_r", rdata, pr);
            chk16("stall_g", gdata, pg);
            chk16("stall_b", bdata, pb);
        end else begin
            if (out_valid === 1'b1) seen_valid++;
            e = model(y, u, v);
            e.vld = vld;
            pipe_q.push_back(e);
            if (pipe_q.size() >= 4) begin
                o = pipe_q.pop_front();
                chk1("out_valid", out_valid, o.vld);
                if (o.vld) begin
                    chk16("r", rdata, o.r);
                    chk16("g", gdata, o.g);
                    chk16("b", bdata, o.b);
                end
            end else begin
                chk1("fill_valid", out_valid, 1'b0);
            end
        end
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t tbl[6];

    initial begin
        tbl[0] = '{y:16'd32768, u:16'd0,     v:16'd0,      r:16'd32768, g:16'd32768, b:16'd32768};
        tbl[1] = '{y:16'd0,     u:16'd0,     v:16'hFC18,   r:16'd0,     g:16'd581,   b:16'd0};
        tbl[2] = '{y:16'd65535, u:16'd10000, v:16'd0,      r:16'd65535, g:16'd61585, b:16'd65535};
        tbl[3] = '{y:16'd1000,  u:16'd0,     v:16'd100,    r:16'd1114,  g:16'd942,   b:16'd1000};
        tbl[4] = '{y:16'd0,     u:16'd0,     v:16'd0,      r:16'd0,     g:16'd0,     b:16'd0};
        tbl[5] = '{y:16'd100,   u:16'hFF9C,  v:16'd0,      r:16'd100,   g:16'd140,   b:16'd0};

        rst_n = 1'b0; clk_en = 1'b0; in_valid = 1'b0;
        ydata = '0; udata = '0; vdata = '0;
        #1;
        chk1("reset_valid", out_valid, 1'b0);
        chk16("reset_r", rdata, 16'd0);
        chk16("reset_g", gdata, 16'd0);
        chk16("reset_b", bdata, 16'd0);
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;

        // Directed vectors: one sample followed by three bubbles.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, tbl[i].y, tbl[i].u, tbl[i].v);
            for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
            chk1("tbl_valid", out_valid, 1'b1);
            chk16("tbl_r", rdata, tbl[i].r);
            chk16("tbl_g", gdata, tbl[i].g);
            chk16("tbl_b", bdata, tbl[i].b);
        end

        // Eight samples with a three-cycle stall mid-burst and one bubble.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                for (int k = 0; k < 3; k++) step(1'b0, 1'($urandom), rnd16(), rnd16(), rnd16());
            end
            if (i == 5) step(1'b1, 1'b0, 16'd1234, 16'd4321, 16'd999);
            step(1'b1, 1'b1, 16'(1000 * (i + 1)), 16'(200 * i), 16'(16'hFF00 + 16'(i)));
        end
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
        chk16("burst_count", 16'(seen_valid), 16'd8);

        // Randomised traffic with random stalls and bubbles.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
                 rnd16(), rnd16(), rnd16());
        end

        // Asynchronous reset with samples in flight.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 16'd30000, 16'd0, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_valid", out_valid, 1'b0);
        chk16("async_rst_r", rdata, 16'd0);
        chk16("async_rst_g", gdata, 16'd0);
        chk16("async_rst_b", bdata, 16'd0);
        pipe_q.delete();
        clk_en = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            chk1("rst_hold_valid", out_valid, 1'b0);
            chk16("rst_hold_r", rdata, 16'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 16'd30000, 16'd0, 16'd0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, rnd16(), rnd16(), rnd16());
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/yuv_rgb.md
YUV_RGB -- requirements
Module: yuv_rgb

Interface
REQ-001 The block SHALL have parameter ROUND, default 1, which selects the shift rounding mode: 1 = round-half-up (add 4096 before the shift), 0 = truncate (floor).
REQ-002 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 Port clk_en, input, 1 bit: pipeline advance enable; when low, all pipeline state holds.
REQ-005 Port in_valid, input, 1 bit: ydata/udata/vdata carry a sample this cycle.
REQ-006 Port ydata, input, 16 bits: luma, unsigned.
REQ-007 Port udata, input, 16 bits: U chroma, two's-complement signed, same scale as Y.
REQ-008 Port vdata, input, 16 bits: V chroma, two's-complement signed, same scale as Y.
REQ-009 Port out_valid, output, 1 bit: rdata/gdata/bdata hold a converted sample.
REQ-010 Ports rdata, gdata, bdata, output, 16 bits each: unsigned, saturated colour components.

Function
REQ-011 Coefficients SHALL be Q2.13 constants: KRV=9339 (1.140), KGU=3236 (0.395), KGV=4760 (0.581), KBU=16646 (2.032).
REQ-012 With rnd=4096 when ROUND=1 and rnd=0 when ROUND=0, the block SHALL compute R = Y + ((KRV*V + rnd) >>> 13).
REQ-013 The block SHALL compute G = Y + ((-KGU*U - KGV*V + rnd) >>> 13).
REQ-014 The block SHALL compute B = Y + ((KBU*U + rnd) >>> 13).
REQ-015 In REQ-012 to REQ-014, >>> SHALL be an arithmetic (floor) shift.
REQ-016 The block SHALL zero-extend Y and sign-extend U and V.
REQ-017 Products SHALL be held in at least 32 signed bits, and sums in at least 34 signed bits, so that no intermediate overflows.
REQ-018 Multiplication SHALL be implemented as registered shift-add trees with no multiplier primitives.
REQ-019 Each result SHALL be clamped: below 0 gives 0, above 65535 gives 65535, otherwise the value passes through unchanged.
REQ-020 The pipeline SHALL have exactly 4 stages:
- S1 registers the inputs and in_valid;
- S2 forms partial shift-add sums;
- S3 completes the products and adds Y;
- S4 rounds, shifts, clamps and registers the outputs.
REQ-021 Latency SHALL be 4 enabled clock edges from input sample to output.
REQ-022 A sample accepted at edge n (clk_en=1, in_valid=1) SHALL appear with out_valid=1 after the 4th subsequent clk_en=1 edge.
REQ-023 Throughput SHALL be one sample per enabled cycle; back-to-back samples SHALL need no bubbles.
REQ-024 When clk_en=0, every stage register, valid bit and output SHALL hold its value; outputs SHALL be unchanged for the whole stall.
REQ-025 When clk_en=1 and in_valid=0, a bubble SHALL propagate, and out_valid SHALL be 0 exactly 4 enabled edges later.
REQ-026 Data registers in a bubble stage SHALL still be allowed to update; consumers SHALL only qualify data with out_valid.
REQ-027 The valid shift chain SHALL be independent of data values.
REQ-028 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-029 While rst_n=0, all valid bits, out_valid, rdata, gdata and bdata SHALL be 0 immediately, without waiting for a clock.
REQ-030 Reset asserted mid-stream SHALL discard every in-flight sample; none may emerge after release.
REQ-031 After rst_n rises, the first out_valid=1 SHALL occur no earlier than 4 enabled edges after the first accepted sample.
REQ-032 rst_n low SHALL override clk_en.

Verification
REQ-033 Neutral grey: Y=32768, U=0, V=0, ROUND=1 -> R=G=B=32768, with out_valid 4 edges later.
REQ-034 Negative V with clamp: Y=0, U=0, V=-1000 (0xFC18) -> R=0 (clamped from -1140), G=581, B=0.
REQ-035 High clamp: Y=65535, U=10000, V=0 -> R=65535, G=61585, B=65535 (clamped).
REQ-036 Rounding: Y=1000, U=0, V=100, ROUND=1 -> R=1114, G=942, B=1000.
REQ-037 Stall and bubble: drive 8 back-to-back samples, hold clk_en=0 for 3 cycles mid-burst, and insert one in_valid=0 -> outputs frozen during the stall, the 8 results emerge in order, and exactly one out_valid=0 gap appears at the bubble position.
REQ-038 Reset mid-burst: pull rst_n low asynchronously (between edges) with 3 samples in flight -> outputs and out_valid are 0 at once, and no stale sample appears after release.
